// File: rtl/vliw_pkg.sv
// Shared VLIW front-end types and widths.
// Used by the instruction-memory responder and its halfword RAM.
package vliw_pkg;

  localparam int INSTR1_W = 32;
  localparam int INSTR2_W = 16;
  localparam int HALF_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    RESP
  } imem_state_t;

  // Even-parity bit: makes the XOR of data plus parity equal zero.
  function automatic logic even_par(input logic [HALF_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_hw_ram.sv
// Halfword instruction RAM: one write port, one async read port.
// Optional IMEM_PARITY_EN stores and rechecks an even-parity bit.
module imem_hw_ram
  import vliw_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [HALF_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [HALF_W-1:0] rdata,
  output logic              rperr
);

`ifdef IMEM_PARITY_EN
  logic [HALF_W:0] mem_q [DEPTH];

  // Store data with its parity bit on top.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= {even_par(wdata), wdata};
    end
  end

  assign rdata = mem_q[raddr][HALF_W-1:0];
  assign rperr = ^mem_q[raddr];
`else
  logic [HALF_W-1:0] mem_q [DEPTH];

  // Plain halfword write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];
  assign rperr = 1'b0;
`endif

endmodule

// File: rtl/imem_bundle_responder.sv
// Serves one 48-bit VLIW bundle per request from three halfword reads.
// Optional IMEM_PARITY_EN reports stored-parity mismatches on resp_perr.
module imem_bundle_responder
  import vliw_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [INSTR1_W-1:0] resp_instr1,
  output logic [INSTR2_W-1:0] resp_instr2,
  output logic                resp_perr,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [HALF_W-1:0]   ld_data
);

  imem_state_t         state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INSTR1_W-1:0] instr1_q, instr1_d;
  logic [INSTR2_W-1:0] instr2_q, instr2_d;
  logic                perr_q, perr_d;
  logic                valid_q, valid_d;

  logic [ADDR_W-1:0]   rd_addr;
  logic [HALF_W-1:0]   rd_data;
  logic                rd_perr;
  logic                wr_en;

  // Port readiness: only IDLE talks to either side; the loader wins ties.
  assign ld_ready  = (state_q == IDLE) && !reset;
  assign req_ready = ld_ready && !ld_valid;
  assign wr_en     = ld_valid && ld_ready;

  // Read address walks base, base+1, base+2, wrapping mod DEPTH.
  always_comb begin
    rd_addr = addr_q;
    unique case (state_q)
      RD1:     rd_addr = addr_q + ADDR_W'(1);
      RD2:     rd_addr = addr_q + ADDR_W'(2);
      default: rd_addr = addr_q;
    endcase
  end

  imem_hw_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (rd_addr),
    .rdata (rd_data),
    .rperr (rd_perr)
  );

  // Next-state and capture logic for the bundle sequencer.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    instr1_d = instr1_q;
    instr2_d = instr2_q;
    perr_d   = perr_q;
    valid_d  = valid_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          perr_d  = 1'b0;
          state_d = RD0;
        end
      end
      RD0: begin
        instr1_d[15:0] = rd_data;
        perr_d         = perr_q | rd_perr;
        state_d        = RD1;
      end
      RD1: begin
        instr1_d[31:16] = rd_data;
        perr_d          = perr_q | rd_perr;
        state_d         = RD2;
      end
      RD2: begin
        instr2_d = rd_data;
        perr_d   = perr_q | rd_perr;
        valid_d  = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any bundle in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      instr1_q <= '0;
      instr2_q <= '0;
      perr_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      instr1_q <= instr1_d;
      instr2_q <= instr2_d;
      perr_q   <= perr_d;
      valid_q  <= valid_d;
    end
  end

  assign resp_valid  = valid_q;
  assign resp_instr1 = instr1_q;
  assign resp_instr2 = instr2_q;
  assign resp_perr   = perr_q;

endmodule

// File: tb/tb_imem_bundle_responder.sv
// Scoreboard bench for imem_bundle_responder.
// Define IMEM_PARITY_EN to also exercise the parity path.
module tb_imem_bundle_responder;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_instr1;
  logic [15:0]       resp_instr2;
  logic              resp_perr;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [15:0]       ld_data;

  imem_bundle_responder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_instr1 (resp_instr1),
    .resp_instr2 (resp_instr2),
    .resp_perr   (resp_perr),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] i1;
    logic [15:0] i2;
    logic        pe;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mem_m [DEPTH];
  logic        bad_m [DEPTH];
  int          vectors = 0;
  int          miscompares = 0;
  int          rr_mode = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int a);
    exp_t e;
    int a0, a1, a2;
    a0 = a % DEPTH;
    a1 = (a + 1) % DEPTH;
    a2 = (a + 2) % DEPTH;
    e.i1 = {mem_m[a1], mem_m[a0]};
    e.i2 = mem_m[a2];
`ifdef IMEM_PARITY_EN
    e.pe = bad_m[a0] | bad_m[a1] | bad_m[a2];
`else
    e.pe = 1'b0;
`endif
    return e;
  endfunction

  // resp_ready generator: 0 = always accept, 1 = stall, else random.
  initial resp_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = 1'b0;
      default: resp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every response handshake.
  logic        hold_prev = 1'b0;
  logic [31:0] p_i1;
  logic [15:0] p_i2;
  logic        p_pe;
  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else if (resp_valid) begin
      if (hold_prev) begin
        chk("hold_instr1", resp_instr1, p_i1);
        chk("hold_instr2", {16'h0, resp_instr2}, {16'h0, p_i2});
        chk("hold_perr", {31'h0, resp_perr}, {31'h0, p_pe});
      end
      chk("resp_readys", {30'h0, req_ready, ld_ready}, 32'h0);
      if (resp_ready) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got %h/%h expected none",
                   resp_instr1, resp_instr2);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("resp_instr1", resp_instr1, e.i1);
          chk("resp_instr2", {16'h0, resp_instr2}, {16'h0, e.i2});
          chk("resp_perr", {31'h0, resp_perr}, {31'h0, e.pe});
        end
        hold_prev = 1'b0;
      end else begin
        hold_prev = 1'b1;
        p_i1 = resp_instr1;
        p_i2 = resp_instr2;
        p_pe = resp_perr;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Entered just after a posedge; returns just after the write edge.
  task automatic do_write(input int a, input logic [15:0] d);
    int n;
    ld_valid = 1'b1;
    ld_addr  = ADDR_W'(a);
    ld_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (ld_ready) break;
      n++;
      if (n > 100) begin
        chk("ld_timeout", 32'h0, 32'h1);
        break;
      end
      @(posedge clk);
      #2;
    end
    mem_m[a % DEPTH] = d;
    bad_m[a % DEPTH] = 1'b0;
    @(posedge clk);
    #2;
    ld_valid = 1'b0;
  endtask

  // Entered just after a posedge; returns just after the accept edge.
  task automatic do_req(input int a);
    int n;
    req_valid = 1'b1;
    req_addr  = ADDR_W'(a);
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 100) begin
        chk("req_timeout", 32'h0, 32'h1);
        break;
      end
      @(posedge clk);
      #2;
    end
    sb_q.push_back(model(a));
    @(posedge clk);
    #2;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || resp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb_q.size(), 32'h0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b1;
    req_addr  = '0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    for (int i = 0; i < DEPTH; i++) bad_m[i] = 1'b0;

    // 1: reset with a request held
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    end
    chk("rst_instr1", resp_instr1, 32'h0);
    chk("rst_instr2", {16'h0, resp_instr2}, 32'h0);
    @(posedge clk);
    #2;
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #2;

    // preload every entry so later reads are defined
    for (int i = 0; i < DEPTH; i++) do_write(i, 16'($urandom));

    // 2: basic bundle with latency
    do_write(4, 16'h1111);
    do_write(5, 16'h2222);
    do_write(6, 16'h3333);
    do_req(4);
    repeat (3) begin
      @(negedge clk);
      chk("lat_not_yet", {31'h0, resp_valid}, 32'h0);
    end
    @(negedge clk);
    chk("lat_valid", {31'h0, resp_valid}, 32'h1);
    chk("basic_instr1", resp_instr1, 32'h2222_1111);
    chk("basic_instr2", {16'h0, resp_instr2}, 32'h3333);
    @(posedge clk);
    #2;
    drain();

    // 3: address wrap
    do_write(63, 16'hAAAA);
    do_write(0, 16'hBBBB);
    do_write(1, 16'hCCCC);
    do_req(63);
    drain();

    // 4: backpressure
    rr_mode = 1;
    do_req(20);
    repeat (6) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'h0, resp_valid}, 32'h1);
    end
    rr_mode = 0;
    @(posedge clk);
    #2;
    @(negedge clk);
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("bp_released", {31'h0, resp_valid}, 32'h0);
    chk("bp_idle_ready", {31'h0, req_ready}, 32'h1);
    drain();

    // 5: write and request together
    ld_valid  = 1'b1;
    ld_addr   = 6'd41;
    ld_data   = 16'h5A5A;
    req_valid = 1'b1;
    req_addr  = 6'd40;
    @(negedge clk);
    chk("tie_req_ready", {31'h0, req_ready}, 32'h0);
    chk("tie_ld_ready", {31'h0, ld_ready}, 32'h1);
    mem_m[41] = 16'h5A5A;
    bad_m[41] = 1'b0;
    @(posedge clk);
    #2;
    ld_valid = 1'b0;
    do_req(40);
    drain();

    // 6: reset during RD1
    req_valid = 1'b1;
    req_addr  = 6'd30;
    @(negedge clk);
    chk("rd1_accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_instr1", resp_instr1, 32'h0);
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_valid", {31'h0, resp_valid}, 32'h0);
    end
    @(posedge clk);
    #2;

`ifdef IMEM_PARITY_EN
    // 7: corrupt one stored bit, then a clean bundle
    u_dut.u_ram.mem_q[5] = u_dut.u_ram.mem_q[5] ^ 17'h00008;
    mem_m[5] = mem_m[5] ^ 16'h0008;
    bad_m[5] = 1'b1;
    do_req(4);
    drain();
    do_req(10);
    drain();
    do_write(5, 16'h2222);
`endif

    // random traffic against the model
    rr_mode = 2;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0)
        do_write($urandom_range(0, DEPTH - 1), 16'($urandom));
      else
        do_req($urandom_range(0, DEPTH - 1));
    end
    drain();
    rr_mode = 0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
